// File: rtl/rs_syndrome_bank_pkg.sv
// Shared GF(2^8) field definition, DVB-T defaults and the alpha-power helper
// used to build constant multipliers at elaboration time.
package rs_syndrome_bank_pkg;

  localparam int             GF_M    = 8;
  localparam logic [GF_M:0]  GF_POLY = 9'h11D;
  localparam int             GF_ORD  = (1 << GF_M) - 1;

  localparam int DVB_N   = 204;
  localparam int DVB_T   = 8;
  localparam int DVB_FCR = 0;

  // alpha^e by repeated multiplication by x; only ever evaluated for constants.
  function automatic logic [GF_M-1:0] alpha_pow(input int e);
    logic [GF_M-1:0] v;
    int              r;
    v = {{(GF_M-1){1'b0}}, 1'b1};
    r = e % GF_ORD;
    for (int i = 0; i < r; i++) begin
      v = {v[GF_M-2:0], 1'b0} ^ (v[GF_M-1] ? GF_POLY[GF_M-1:0] : {GF_M{1'b0}});
    end
    return v;
  endfunction

endpackage

// File: rtl/rs_syndrome_bank_if.sv
// Symbol input stream and syndrome output stream of the syndrome bank.
interface rs_syndrome_bank_if #(
  parameter int M = 8,
  parameter int T = 8
);
  localparam int IDXW = (2 * T > 1) ? $clog2(2 * T) : 1;

  logic            In_Valid;
  logic            In_Sof;
  logic [M-1:0]    Msg_Rsv;
  logic            Syn_Valid;
  logic [IDXW-1:0] Syn_Idx;
  logic [M-1:0]    S_i;
  logic            Err_Flag;
  logic            Done;
  logic            Frame_Err;

  modport master (
    output In_Valid, In_Sof, Msg_Rsv,
    input  Syn_Valid, Syn_Idx, S_i, Err_Flag, Done, Frame_Err
  );

  modport slave (
    input  In_Valid, In_Sof, Msg_Rsv,
    output Syn_Valid, Syn_Idx, S_i, Err_Flag, Done, Frame_Err
  );
endinterface

// File: rtl/rs_syndrome_bank_gf_const_mult.sv
// Multiply by the fixed field element alpha^E: each input bit selects the
// column alpha^(E+i), and the selected columns are XORed together.
module gf_const_mult
  import rs_syndrome_bank_pkg::*;
#(
  parameter int E = 0
) (
  input  logic [GF_M-1:0] din,
  output logic [GF_M-1:0] dout
);

  logic [GF_M-1:0][GF_M-1:0] term;

  generate
    for (genvar gi = 0; gi < GF_M; gi++) begin : g_col
      localparam logic [GF_M-1:0] COL = alpha_pow(E + gi);
      assign term[gi] = din[gi] ? COL : {GF_M{1'b0}};
    end
  endgenerate

  always_comb begin
    dout = '0;
    for (int i = 0; i < GF_M; i++) begin
      dout = dout ^ term[i];
    end
  end

endmodule

// File: rtl/rs_syndrome_bank.sv
// Parallel Reed-Solomon syndrome accumulator with a shadow bank so one
// codeword's syndromes stream out while the next codeword accumulates.
module rs_syndrome_bank
  import rs_syndrome_bank_pkg::*;
#(
  parameter int N   = DVB_N,
  parameter int T   = DVB_T,
  parameter int FCR = DVB_FCR,
  parameter int M   = GF_M
) (
  input  logic              Clk,
  input  logic              Reset,
  rs_syndrome_bank_if.slave bus
);

  localparam int NS   = 2 * T;
  localparam int IDXW = (NS > 1) ? $clog2(NS) : 1;
  localparam int CW   = $clog2(N + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NS - 1);

  generate
    if (NS > N || M != GF_M) begin : g_param_bad
      $error("rs_syndrome_bank: need 2T <= N and M == GF_M");
    end
  endgenerate

  logic [NS-1:0][M-1:0] acc_q, acc_d, acc_upd, shadow_q, shadow_d, mult_out;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_upd;
  logic                 open_q, open_d;
  logic                 syn_valid_q, syn_valid_d;
  logic [IDXW-1:0]      syn_idx_q, syn_idx_d, idx_nxt;
  logic [M-1:0]         s_i_q, s_i_d;
  logic                 err_flag_q, err_flag_d;
  logic                 done_q, done_d;
  logic                 frame_err_q, frame_err_d;
  logic                 accept_sof, accept, last;

  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_mul
      gf_const_mult #(.E(FCR + gi)) u_mul (
        .din  (acc_q[gi]),
        .dout (mult_out[gi])
      );
    end
  endgenerate

  always_comb begin
    accept_sof = bus.In_Valid & bus.In_Sof;
    accept     = accept_sof | (bus.In_Valid & open_q);
    cnt_upd    = accept_sof ? CW'(1) : cnt_q + CW'(1);
    for (int j = 0; j < NS; j++) begin
      acc_upd[j] = accept_sof ? bus.Msg_Rsv : (mult_out[j] ^ bus.Msg_Rsv);
    end
    last    = accept && (cnt_upd == CW'(N));
    idx_nxt = syn_idx_q + IDXW'(1);

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    open_d      = open_q;
    shadow_d    = shadow_q;
    syn_valid_d = 1'b0;
    syn_idx_d   = '0;
    s_i_d       = '0;
    err_flag_d  = 1'b0;
    done_d      = 1'b0;
    // SOF on an open codeword aborts it; the new one starts in the same cycle.
    frame_err_d = accept_sof & open_q;

    if (accept) begin
      if (last) begin
        acc_d  = '0;
        cnt_d  = '0;
        open_d = 1'b0;
      end else begin
        acc_d  = acc_upd;
        cnt_d  = cnt_upd;
        open_d = 1'b1;
      end
    end

    // The completing edge presents S_0 directly; the shadow supplies the rest.
    if (last) begin
      shadow_d    = acc_upd;
      syn_valid_d = 1'b1;
      s_i_d       = acc_upd[0];
      err_flag_d  = |acc_upd;
      done_d      = (LAST_IDX == '0);
    end else if (syn_valid_q && syn_idx_q != LAST_IDX) begin
      syn_valid_d = 1'b1;
      syn_idx_d   = idx_nxt;
      s_i_d       = shadow_q[idx_nxt];
      err_flag_d  = err_flag_q;
      done_d      = (idx_nxt == LAST_IDX);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      open_q      <= 1'b0;
      shadow_q    <= '0;
      syn_valid_q <= 1'b0;
      syn_idx_q   <= '0;
      s_i_q       <= '0;
      err_flag_q  <= 1'b0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      open_q      <= open_d;
      shadow_q    <= shadow_d;
      syn_valid_q <= syn_valid_d;
      syn_idx_q   <= syn_idx_d;
      s_i_q       <= s_i_d;
      err_flag_q  <= err_flag_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.Syn_Valid = syn_valid_q;
  assign bus.Syn_Idx   = syn_idx_q;
  assign bus.S_i       = s_i_q;
  assign bus.Err_Flag  = err_flag_q;
  assign bus.Done      = done_q;
  assign bus.Frame_Err = frame_err_q;

endmodule

// File: tb/tb_rs_syndrome_bank.sv
// Scoreboard bench for rs_syndrome_bank: expected syndromes are computed by a
// Horner model when a codeword's last symbol is driven and compared on unload.
module tb_rs_syndrome_bank;

  localparam int N   = 204;
  localparam int T   = 8;
  localparam int FCR = 0;
  localparam int NS  = 2 * T;

  typedef struct {
    int         cyc;
    logic [3:0] idx;
    logic [7:0] s;
    logic       err;
    logic       done;
  } exp_t;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;

  exp_t       sb[$];
  int         fe_q[$];
  exp_t       mon_e;
  logic [7:0] cw [N];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  rs_syndrome_bank_if #(.M(8), .T(T)) bus ();

  rs_syndrome_bank #(.N(N), .T(T), .FCR(FCR), .M(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] a, p;
    a = a_in;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  task automatic push_expected(input int k);
    logic [7:0] syn [NS];
    logic       err;
    logic [7:0] aj, s;
    err = 1'b0;
    for (int j = 0; j < NS; j++) begin
      aj = 8'h01;
      for (int e = 0; e < FCR + j; e++) aj = gf_mul(aj, 8'h02);
      s = 8'h00;
      for (int i = 0; i < N; i++) s = gf_mul(s, aj) ^ cw[i];
      syn[j] = s;
      if (s != 8'h00) err = 1'b1;
    end
    for (int j = 0; j < NS; j++) begin
      sb.push_back('{cyc: k + 1 + j, idx: 4'(j), s: syn[j], err: err, done: (j == NS - 1)});
    end
    $display("codeword queued: last symbol cycle %0d, S0=%02h S1=%02h S8=%02h S15=%02h err=%0b",
             k, syn[0], syn[1], syn[8], syn[15], err);
  endtask

  task automatic drive(input logic v, input logic sof, input logic [7:0] d);
    @(posedge Clk);
    #1;
    bus.In_Valid = v;
    bus.In_Sof   = sof;
    bus.Msg_Rsv  = d;
  endtask

  task automatic send_cw(input int gap_max, input bit aborts_open);
    for (int i = 0; i < N; i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) drive(1'b0, 1'b0, 8'($urandom));
      end
      drive(1'b1, (i == 0), cw[i]);
      if (i == 0 && aborts_open) fe_q.push_back(cyc + 1);
      if (i == N - 1) push_expected(cyc);
    end
  endtask

  task automatic fill_cw(input int pos, input logic [7:0] val);
    for (int i = 0; i < N; i++) cw[i] = 8'h00;
    if (pos >= 0) cw[pos] = val;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 100 && (sb.size() > 0 || fe_q.size() > 0); i++) @(negedge Clk);
    check({tag, "_drain_sb"}, sb.size(), 0);
    check({tag, "_drain_fe"}, fe_q.size(), 0);
  endtask

  always @(negedge Clk) begin
    if (Reset) begin
      if (bus.Syn_Valid) begin
        if (sb.size() == 0) begin
          check("unexpected_syn_valid", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("S%0d_cycle", mon_e.idx), cyc, mon_e.cyc);
          check($sformatf("S%0d_idx", mon_e.idx), bus.Syn_Idx, mon_e.idx);
          check($sformatf("S%0d_value", mon_e.idx), bus.S_i, mon_e.s);
          check($sformatf("S%0d_err", mon_e.idx), bus.Err_Flag, mon_e.err);
          check($sformatf("S%0d_done", mon_e.idx), bus.Done, mon_e.done);
        end
      end else begin
        check("idle_S_i", bus.S_i, 0);
        check("idle_done", bus.Done, 0);
      end
      if (bus.Frame_Err) begin
        if (fe_q.size() == 0) check("unexpected_frame_err", 1, 0);
        else check("frame_err_cycle", cyc, fe_q.pop_front());
      end
    end
  end

  initial begin
    bus.In_Valid = 1'b0;
    bus.In_Sof   = 1'b0;
    bus.Msg_Rsv  = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_syn_valid", bus.Syn_Valid, 0);
    check("rst_S_i", bus.S_i, 0);
    check("rst_err", bus.Err_Flag, 0);
    check("rst_frame_err", bus.Frame_Err, 0);
    Reset = 1'b1;

    // Stray symbols with no codeword open must be ignored.
    repeat (3) drive(1'b1, 1'b0, 8'hFF);

    fill_cw(-1, 8'h00);
    send_cw(0, 1'b0);
    drive(1'b0, 1'b0, 8'h00);
    wait_drain("zeros");

    // Back-to-back: last-symbol-only codeword then all zeros, no gap.
    fill_cw(N - 1, 8'h01);
    send_cw(0, 1'b0);
    fill_cw(-1, 8'h00);
    send_cw(0, 1'b0);
    drive(1'b0, 1'b0, 8'h00);
    wait_drain("b2b");

    fill_cw(N - 2, 8'h01);
    send_cw(3, 1'b0);
    drive(1'b0, 1'b0, 8'h00);
    wait_drain("gaps");

    // Open a codeword, reach count 100, then restart with a new SOF.
    drive(1'b1, 1'b1, 8'($urandom));
    repeat (99) drive(1'b1, 1'b0, 8'($urandom));
    fill_cw(N - 2, 8'h01);
    send_cw(0, 1'b1);
    drive(1'b0, 1'b0, 8'h00);
    wait_drain("abort");

    // Reset in the middle of an unload.
    fill_cw(N - 1, 8'h01);
    send_cw(0, 1'b0);
    drive(1'b0, 1'b0, 8'h00);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(negedge Clk);
        if (bus.Syn_Valid && bus.Syn_Idx == 4'd5) seen = 1'b1;
      end
      check("reach_idx5", seen, 1);
    end
    #1;
    Reset = 1'b0;
    #1;
    check("midrst_syn_valid", bus.Syn_Valid, 0);
    check("midrst_idx", bus.Syn_Idx, 0);
    check("midrst_S_i", bus.S_i, 0);
    check("midrst_err", bus.Err_Flag, 0);
    check("midrst_done", bus.Done, 0);
    sb.delete();
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    Reset = 1'b1;
    repeat (25) drive(1'b0, 1'b0, 8'h00);

    fill_cw(-1, 8'h00);
    send_cw(0, 1'b0);
    drive(1'b0, 1'b0, 8'h00);
    wait_drain("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_syndrome_bank.md
RS_SYNDROME_BANK -- requirements
Module: rs_syndrome_bank

Interface
REQ-001 Parameter N, default 204: codeword length in symbols (DVB-T shortened RS(204,188)).
REQ-002 Parameter T, default 8: correctable symbols; 2T syndromes are produced.
REQ-003 Parameter FCR, default 0: first consecutive root; syndrome j is evaluated at alpha^(FCR+j).
REQ-004 Parameter M, default 8: symbol width; field GF(2^8), primitive polynomial 0x11D.
REQ-005 Clk  in  1  the single clock; all state updates on the rising edge.
REQ-006 Reset  in  1  asynchronous, active-low reset.
REQ-007 In_Valid  in  1  Msg_Rsv carries a symbol this cycle.
REQ-008 In_Sof  in  1  qualified by In_Valid; marks the first symbol of a codeword.
REQ-009 Msg_Rsv  in  M  received symbol, highest-degree coefficient first.
REQ-010 Syn_Valid  out  1  S_i and Syn_Idx are valid this cycle.
REQ-011 Syn_Idx  out  clog2(2T)  index j of the syndrome on S_i.
REQ-012 S_i  out  M  syndrome S_j, polynomial-basis tuple.
REQ-013 Err_Flag  out  1  at least one syndrome of the codeword being unloaded is nonzero.
REQ-014 Done  out  1  one-cycle pulse coinciding with the last syndrome (j = 2T-1).
REQ-015 Frame_Err  out  1  one-cycle pulse when a codeword is aborted.

Function
REQ-016 The block SHALL hold 2T accumulators and update all of them in parallel on each accepted symbol: S_j <= (S_j * alpha^(FCR+j)) XOR Msg_Rsv.
REQ-017 On In_Valid with In_Sof, accumulators SHALL load Msg_Rsv directly, discarding prior contents, and the symbol count SHALL become 1.
REQ-018 Cycles with In_Valid=0 SHALL leave accumulators and count unchanged; gaps of any length SHALL be supported.
REQ-019 In_Valid without In_Sof while no codeword is open SHALL be ignored.
REQ-020 When the count reaches N, the 2T results SHALL be copied to a shadow bank the following edge, the accumulator bank SHALL return to idle, and Err_Flag SHALL be the OR-reduction of the shadow bank.
REQ-021 If the last symbol is accepted in cycle k, the shadow bank SHALL emit S_0 in cycle k+1 and S_(2T-1) in cycle k+2T, one per cycle, Syn_Idx incrementing from 0, with Done in cycle k+2T.
REQ-022 Err_Flag SHALL be valid and stable from cycle k+1 through k+2T.
REQ-023 A new codeword MAY start in cycle k+1; unload and accumulation SHALL overlap without stalls (requires 2T <= N, checked at elaboration).
REQ-024 In_Sof arriving while a codeword is open with count < N SHALL pulse Frame_Err, abort the open codeword (no unload), and start the new one per REQ-017.
REQ-025 S_i SHALL be 0 whenever Syn_Valid = 0 (no tri-state outputs).
REQ-026 Constant multiplication SHALL be combinational polynomial-basis XOR networks; no log/antilog tables in the datapath.
REQ-027 The symbol counter SHALL be clog2(N+1) bits wide and never wrap.

Reset
REQ-028 Reset low SHALL asynchronously clear accumulators, shadow bank, counters, Syn_Valid, Syn_Idx, S_i, Err_Flag, Done, and Frame_Err to 0 and close any open codeword.
REQ-029 An in-progress unload interrupted by reset SHALL NOT resume; the next output SHALL come from a codeword whose In_Sof follows reset release.

Structure
REQ-030 A shared package SHALL hold the field polynomial, M, the alpha-power constant function, and the DVB-T defaults (N=204, T=8, FCR=0).
REQ-031 One sub-module, gf_const_mult (parameter: exponent e; M-bit in/out, out = in * alpha^e), SHALL be instantiated 2T times.

Verification
REQ-032 Reset, then 204 zero symbols -> S_0..S_15 all 0x00, Err_Flag=0, Done at k+16.
REQ-033 Only the last symbol = 0x01 -> all sixteen S_j = 0x01, Err_Flag=1.
REQ-034 Only symbol N-2 = 0x01 -> S_j = alpha^j: S_0=0x01, S_1=0x02, S_7=0x80, S_8=0x1D, S_15=0x26.
REQ-035 Two back-to-back codewords (REQ-033 then REQ-032) with no gap -> correct syndromes for both, second unload starting at k2+1, Done pulsed twice.
REQ-036 Random In_Valid gaps on the REQ-034 codeword -> identical syndromes. A second In_Sof at count 100 -> Frame_Err pulse, no unload for the aborted codeword.
REQ-037 Reset asserted at Syn_Idx=5 -> all outputs 0 immediately. A subsequent REQ-032 codeword -> correct output.
